// File: rtl/multi_ch_serial_out.sv
// UART-fed pattern generator: byte packs load per-channel
// shadow patterns, each channel shifts its pattern out LSB first.
// Optional trailing checksum byte: define PACK_CHECKSUM_EN.
// Ports: clk, rst (sync, active-high), i_data/i_rx_done_tick (byte in),
// o_serial_out/o_bit_tick/o_done_tick/o_busy per channel, o_pack_err.
module multi_ch_serial_out #(
  parameter int DATA_BIT    = 32,
  parameter int CH_NUM      = 4,
  parameter int FAST_DIV    = 10,
  parameter int SLOW_DIV    = 40,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_data,
  input  logic              i_rx_done_tick,
  output logic [CH_NUM-1:0] o_serial_out,
  output logic [CH_NUM-1:0] o_bit_tick,
  output logic [CH_NUM-1:0] o_done_tick,
  output logic [CH_NUM-1:0] o_busy,
  output logic              o_pack_err
);

  localparam int NB = DATA_BIT / 8;
  localparam int CW = $clog2(SLOW_DIV + 1);
  localparam int IW = $clog2(DATA_BIT);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]    NB_M1   = 4'(NB - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] FAST_M1 = CW'(FAST_DIV - 1);
  localparam logic [CW-1:0] SLOW_M1 = CW'(SLOW_DIV - 1);
  localparam logic [IW-1:0] LAST    = IW'(DATA_BIT - 1);

  // IDLE doubles as "expecting the channel byte"
  typedef enum logic [2:0] {
    A_IDLE, A_OUT, A_FREQ, A_CTRL, A_SUM
  } asm_t;
  typedef enum logic {C_IDLE, C_RUN} ch_t;

  asm_t                r_st;
  logic [7:0]          r_ch;
  logic [3:0]          r_bcnt;
  logic [DATA_BIT-1:0] r_out;
  logic [DATA_BIT-1:0] r_freq;
  logic [TW-1:0]       r_to;
  logic                r_err;
  logic                r_cmd_vld;
  logic [7:0]          r_cmd_ch;
  logic                r_cmd_start;
  logic                r_cmd_stop;
  logic [DATA_BIT-1:0] r_sh_out  [CH_NUM];
  logic [DATA_BIT-1:0] r_sh_freq [CH_NUM];
  logic [CH_NUM-1:0]   r_sh_rep;
`ifdef PACK_CHECKSUM_EN
  logic [7:0]          r_ctrl;
  logic [7:0]          r_sum;
`endif

  logic       w_fin;
  logic       w_bad;
  logic       w_ok;
  logic [7:0] w_ctrl;

  assign w_ok = (r_ch < 8'(CH_NUM));

  always_comb begin
    w_fin  = 1'b0;
    w_bad  = 1'b0;
    w_ctrl = i_data;
`ifdef PACK_CHECKSUM_EN
    w_ctrl = r_ctrl;
    if (i_rx_done_tick && r_st == A_SUM) begin
      w_fin = (i_data == r_sum);
      w_bad = (i_data != r_sum);
    end
`else
    if (i_rx_done_tick && r_st == A_CTRL)
      w_fin = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st        <= A_IDLE;
      r_ch        <= '0;
      r_bcnt      <= '0;
      r_out       <= '0;
      r_freq      <= '0;
      r_to        <= '0;
      r_err       <= 1'b0;
      r_cmd_vld   <= 1'b0;
      r_cmd_ch    <= '0;
      r_cmd_start <= 1'b0;
      r_cmd_stop  <= 1'b0;
      r_sh_rep    <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_sh_out[i]  <= '0;
        r_sh_freq[i] <= '0;
      end
`ifdef PACK_CHECKSUM_EN
      r_ctrl      <= '0;
      r_sum       <= '0;
`endif
    end else begin
      r_err     <= 1'b0;
      r_cmd_vld <= 1'b0;
      if (i_rx_done_tick) begin
        r_to <= '0;
`ifdef PACK_CHECKSUM_EN
        r_sum <= r_sum + i_data;
`endif
        unique case (r_st)
          A_IDLE: begin
            r_ch   <= i_data;
            r_bcnt <= '0;
            r_st   <= A_OUT;
`ifdef PACK_CHECKSUM_EN
            r_sum  <= i_data;
`endif
          end
          A_OUT: begin
            r_out <= (r_out << 8) | DATA_BIT'(i_data);
            if (r_bcnt == NB_M1) begin
              r_bcnt <= '0;
              r_st   <= A_FREQ;
            end else begin
              r_bcnt <= r_bcnt + 4'd1;
            end
          end
          A_FREQ: begin
            r_freq <= (r_freq << 8) | DATA_BIT'(i_data);
            if (r_bcnt == NB_M1) begin
              r_bcnt <= '0;
              r_st   <= A_CTRL;
            end else begin
              r_bcnt <= r_bcnt + 4'd1;
            end
          end
          A_CTRL: begin
`ifdef PACK_CHECKSUM_EN
            r_ctrl <= i_data;
            r_st   <= A_SUM;
`else
            r_st   <= A_IDLE;
`endif
          end
          default: r_st <= A_IDLE;
        endcase
        if (w_fin) begin
          if (w_ok) begin
            r_cmd_vld   <= 1'b1;
            r_cmd_ch    <= r_ch;
            r_cmd_start <= w_ctrl[0];
            r_cmd_stop  <= w_ctrl[2];
            for (int i = 0; i < CH_NUM; i++) begin
              if (r_ch == 8'(i)) begin
                r_sh_out[i]  <= r_out;
                r_sh_freq[i] <= r_freq;
                r_sh_rep[i]  <= w_ctrl[1];
              end
            end
          end else begin
            r_err <= 1'b1;
          end
        end
        if (w_bad)
          r_err <= 1'b1;
      end else if (r_st != A_IDLE) begin
        if (r_to == TO_M1) begin
          r_st  <= A_IDLE;
          r_err <= 1'b1;
          r_to  <= '0;
        end else begin
          r_to <= r_to + TW'(1);
        end
      end
    end
  end

  assign o_pack_err = r_err;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    ch_t                 r_cs;
    logic [DATA_BIT-1:0] r_wo;
    logic [DATA_BIT-1:0] r_wf;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_cnt;
    logic                r_ser;
    logic                r_bt;
    logic                r_dt;
    logic                w_hit;
    logic                w_end;
    logic [IW-1:0]       w_nidx;

    assign w_hit  = r_cmd_vld && (r_cmd_ch == 8'(g));
    assign w_end  = (r_cnt == (r_wf[r_idx] ? FAST_M1 : SLOW_M1));
    assign w_nidx = r_idx + IW'(1);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cs  <= C_IDLE;
        r_wo  <= '0;
        r_wf  <= '0;
        r_idx <= '0;
        r_cnt <= '0;
        r_ser <= 1'b0;
        r_bt  <= 1'b0;
        r_dt  <= 1'b0;
      end else begin
        r_bt <= 1'b0;
        r_dt <= 1'b0;
        if (w_hit && r_cmd_stop) begin
          r_cs  <= C_IDLE;
          r_ser <= 1'b0;
        end else if (w_hit && r_cmd_start) begin
          r_cs  <= C_RUN;
          r_wo  <= r_sh_out[g];
          r_wf  <= r_sh_freq[g];
          r_idx <= '0;
          r_cnt <= '0;
          r_ser <= r_sh_out[g][0];
          r_bt  <= 1'b1;
        end else if (r_cs == C_RUN) begin
          if (!w_end) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= '0;
            if (r_idx == LAST) begin
              r_dt  <= 1'b1;
              r_idx <= '0;
              // repeat reloads the shadow so a fresh pack takes effect
              if (r_sh_rep[g]) begin
                r_wo  <= r_sh_out[g];
                r_wf  <= r_sh_freq[g];
                r_ser <= r_sh_out[g][0];
                r_bt  <= 1'b1;
              end else begin
                r_cs  <= C_IDLE;
                r_ser <= 1'b0;
              end
            end else begin
              r_idx <= w_nidx;
              r_ser <= r_wo[w_nidx];
              r_bt  <= 1'b1;
            end
          end
        end
      end
    end

    assign o_serial_out[g] = r_ser;
    assign o_bit_tick[g]   = r_bt;
    assign o_done_tick[g]  = r_dt;
    assign o_busy[g]       = (r_cs == C_RUN);
  end

endmodule

// File: tb/tb_multi_ch_serial_out.sv
// Directed bench for multi_ch_serial_out.
// Small dividers and timeout so whole patterns fit in a short run.
module tb_multi_ch_serial_out;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_tick;
  logic [3:0] ser, bt, dt, busy;
  logic       perr;

  int n_tests = 0;
  int n_fail  = 0;
  int n_err   = 0;
  int n_done0 = 0;

  multi_ch_serial_out #(
    .DATA_BIT(32), .CH_NUM(4), .FAST_DIV(4),
    .SLOW_DIV(8), .TIMEOUT_CYC(200)
  ) dut (
    .clk(clk), .rst(rst),
    .i_data(rx_data), .i_rx_done_tick(rx_tick),
    .o_serial_out(ser), .o_bit_tick(bt),
    .o_done_tick(dt), .o_busy(busy),
    .o_pack_err(perr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (perr) n_err++;
    if (dt[0]) n_done0++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_tick = 1'b1;
    @(negedge clk);
    rx_tick = 1'b0;
  endtask

  // sadj is added to the checksum byte to corrupt it
  task automatic send_pack(input logic [7:0] ch,
                           input logic [31:0] o,
                           input logic [31:0] f,
                           input logic [7:0] c,
                           input logic [7:0] sadj);
    logic [7:0] s;
    s = ch;
    send_byte(ch);
    for (int i = 3; i >= 0; i--) begin
      s = s + o[i*8 +: 8];
      send_byte(o[i*8 +: 8]);
    end
    for (int i = 3; i >= 0; i--) begin
      s = s + f[i*8 +: 8];
      send_byte(f[i*8 +: 8]);
    end
    s = s + c;
    send_byte(c);
`ifdef PACK_CHECKSUM_EN
    send_byte(s + sadj);
`else
    if (sadj != 8'd0 && s == 8'd0) rx_data = 8'd0;
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism, nbt, nd, e0, d0;
    logic [31:0] acc;
    logic [3:0] oth;
    rst = 1'b1;
    rx_data = 8'd0;
    rx_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {ser, bt, dt, busy, perr}, 17'd0);
    rst = 1'b0;
    @(negedge clk);

    // ch1 single shot, all fast bits
    send_pack(8'd1, 32'h0000_00A5, 32'hFFFF_FFFF, 8'h01, 8'd0);
    mism = 0; nbt = 0; nd = 0; acc = '0; oth = '0;
    for (int c = 0; c <= 128; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("t1_first_bit", ser[1], 1'b1);
        chk("t1_first_tick", bt[1], 1'b1);
      end
      if (c < 128) begin
        if (ser[1] !== ((c / 4 < 8) ? ((8'hA5 >> (c / 4)) & 1) : 0))
          mism++;
        if (c % 4 == 2) acc[c / 4] = ser[1];
        nbt += int'(bt[1]);
        nd  += int'(dt[1]);
        oth |= (ser | busy | dt) & 4'b1101;
      end else begin
        chk("t1_done_at_128", dt[1], 1'b1);
        chk("t1_idle_after", {busy[1], ser[1]}, 2'b00);
      end
    end
    chk("t1_wave_mism", mism, 0);
    chk("t1_pattern", acc, 32'h0000_00A5);
    chk("t1_bit_ticks", nbt, 32);
    chk("t1_early_done", nd, 0);
    chk("t1_other_ch", oth, 4'b0000);

    // ch0 repeat, bit0 fast, bits1..31 slow
    send_pack(8'd0, 32'h0000_0003, 32'h0000_0001, 8'h03, 8'd0);
    nd = 0; mism = 0;
    for (int c = 0; c <= 505; c++) begin
      @(negedge clk);
      if (c == 0)  chk("t2_bit0", {ser[0], bt[0]}, 2'b11);
      if (c == 3)  chk("t2_bit0_end", ser[0], 1'b1);
      if (c == 4)  chk("t2_bit1_tick", bt[0], 1'b1);
      if (c == 11) chk("t2_bit1_end", ser[0], 1'b1);
      if (c == 12) chk("t2_bit2", ser[0], 1'b0);
      if (c == 252) chk("t2_rep_restart", {dt[0], bt[0], ser[0]}, 3'b111);
      if (c == 504) chk("t2_rep_second", dt[0], 1'b1);
      if (!busy[0]) mism++;
      nd += int'(dt[0]);
    end
    chk("t2_done_count", nd, 2);
    chk("t2_no_gap", mism, 0);

    // STOP while repeating
    send_pack(8'd0, 32'h0, 32'h0, 8'h05, 8'd0);
    d0 = n_done0;
    @(negedge clk);
    chk("t3_stop", {ser[0], busy[0]}, 2'b00);
    repeat (300) @(negedge clk);
    chk("t3_no_done", n_done0 - d0, 0);

    // out-of-range channel, then a timed-out partial pack
    e0 = n_err;
    send_pack(8'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h01, 8'd0);
    chk("t4_bad_ch_err", perr, 1'b1);
    @(negedge clk);
    chk("t4_err_one_cycle", perr, 1'b0);
    chk("t4_no_change", {busy, ser}, 8'd0);
    send_byte(8'd2);
    send_byte(8'd0);
    send_byte(8'd0);
    repeat (205) @(negedge clk);
    chk("t4_err_total", n_err - e0, 2);
    send_pack(8'd2, 32'h0000_0001, 32'hFFFF_FFFF, 8'h01, 8'd0);
    @(negedge clk);
    chk("t4_accept", {busy[2], ser[2], bt[2]}, 3'b111);
    chk("t4_no_more_err", n_err - e0, 2);

    // restart ch2 with a new pattern mid-run
    send_pack(8'd2, 32'h0000_0002, 32'hFFFF_FFFF, 8'h01, 8'd0);
    nd = 0;
    for (int c = 0; c <= 128; c++) begin
      @(negedge clk);
      if (c == 0) chk("t5_restart", {ser[2], bt[2]}, 2'b01);
      if (c == 4) chk("t5_bit1", ser[2], 1'b1);
      if (c < 128) nd += int'(dt[2]);
      if (c == 128) chk("t5_done", dt[2], 1'b1);
    end
    chk("t5_no_abort_done", nd, 0);

`ifdef PACK_CHECKSUM_EN
    e0 = n_err;
    send_pack(8'd1, 32'h0000_00FF, 32'hFFFF_FFFF, 8'h01, 8'd1);
    chk("t6_sum_err", perr, 1'b1);
    @(negedge clk);
    chk("t6_no_start", busy[1], 1'b0);
    send_pack(8'd1, 32'h0000_00FF, 32'hFFFF_FFFF, 8'h01, 8'd0);
    @(negedge clk);
    chk("t6_sum_ok", {busy[1], ser[1]}, 2'b11);
    chk("t6_err_total", n_err - e0, 1);
`endif

    // reset in the middle of a repeating pattern
    send_pack(8'd3, 32'hFFFF_FFFF, 32'h0, 8'h03, 8'd0);
    repeat (10) @(negedge clk);
    chk("t7_running", {busy[3], ser[3]}, 2'b11);
    e0 = n_err;
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_outs", {ser, bt, dt, busy, perr}, 17'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t7_after_rst", {ser, busy, n_err - e0}, 40'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
